dcache_miss_ctrl: RTL and testbench



---
 rtl/dcache_miss_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss/refill controller: writes back a dirty victim, fetches the missing line over a beat-serial bus, commits it in one cycle.
// Optional miss/writeback event counters are enabled by defining DCACHE_MISS_CNT_EN.
module dcache_miss_ctrl #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 512
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_mem_access,
  input  logic                   i_dcache_hit,
  input  logic                   i_dcache_dirty,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [ADDR_WIDTH-1:0]  i_addr_wb,
  input  logic [BLOCK_WIDTH-1:0] i_victim_block,
  output logic                   o_stall,
  output logic                   o_block_we,
  output logic [BLOCK_WIDTH-1:0] o_data_block,
  output logic                   o_wr_req_valid,
  input  logic                   i_wr_req_ready,
  output logic [ADDR_WIDTH-1:0]  o_wr_addr,
  output logic                   o_wr_data_valid,
  input  logic                   i_wr_data_ready,
  output logic [DATA_WIDTH-1:0]  o_wr_data,
  output logic                   o_wr_last,
  input  logic                   i_wr_resp_valid,
  output logic                   o_rd_req_valid,
  input  logic                   i_rd_req_ready,
  output logic [ADDR_WIDTH-1:0]  o_rd_addr,
  input  logic                   i_rd_data_valid,
  input  logic [DATA_WIDTH-1:0]  i_rd_data
`ifdef DCACHE_MISS_CNT_EN
  ,
  output logic [31:0]            o_miss_count,
  output logic [31:0]            o_wb_count
`endif
);

  localparam int BEATS = BLOCK_WIDTH / DATA_WIDTH;
  localparam int OFFS  = $clog2(BLOCK_WIDTH / 8);
  localparam int CNTW  = $clog2(BEATS);
  localparam int DSH   = $clog2(DATA_WIDTH);
  localparam int SLOTW = $clog2(BLOCK_WIDTH);
  localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB_ADDR,
    WB_DATA,
    WB_RESP,
    RF_ADDR,
    RF_DATA,
    RF_WRITE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CNTW-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]  r_wbAddr;
  logic [ADDR_WIDTH-1:0]  r_rfAddr;
  logic [BLOCK_WIDTH-1:0] r_victim;
  logic [BLOCK_WIDTH-1:0] r_refill;
  logic                   w_miss;
  logic [SLOTW-1:0]       w_slotBase;
  logic                   w_unused;

  assign w_miss     = i_mem_access & ~i_dcache_hit;
  assign w_slotBase = {r_cnt, {DSH{1'b0}}};
  assign w_unused   = ^{i_addr[OFFS-1:0], i_addr_wb[OFFS-1:0]};

  always_ff @(posedge i_clk) begin
    if (i_arst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    o_wr_req_valid  = 1'b0;
    o_wr_data_valid = 1'b0;
    o_wr_last       = 1'b0;
    o_rd_req_valid  = 1'b0;
    o_block_we      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_miss) w_next = i_dcache_dirty ? WB_ADDR : RF_ADDR;
      end
      WB_ADDR: begin
        o_wr_req_valid = 1'b1;
        if (i_wr_req_ready) w_next = WB_DATA;
      end
      WB_DATA: begin
        o_wr_data_valid = 1'b1;
        o_wr_last       = (r_cnt == LAST_BEAT);
        if (i_wr_data_ready && (r_cnt == LAST_BEAT)) w_next = WB_RESP;
      end
      WB_RESP: begin
        if (i_wr_resp_valid) w_next = RF_ADDR;
      end
      RF_ADDR: begin
        o_rd_req_valid = 1'b1;
        if (i_rd_req_ready) w_next = RF_DATA;
      end
      RF_DATA: begin
        if (i_rd_data_valid && (r_cnt == LAST_BEAT)) w_next = RF_WRITE;
      end
      RF_WRITE: begin
        o_block_we = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Miss is sampled only in IDLE; line addresses are latched with the block offset cleared
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_cnt    <= '0;
      r_wbAddr <= '0;
      r_rfAddr <= '0;
      r_victim <= '0;
      r_refill <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_rfAddr <= {i_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
            if (i_dcache_dirty) begin
              r_wbAddr <= {i_addr_wb[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
              r_victim <= i_victim_block;
            end
          end
        end
        WB_ADDR: if (i_wr_req_ready) r_cnt <= '0;
        WB_DATA: if (i_wr_data_ready) r_cnt <= r_cnt + 1'b1;
        RF_ADDR: if (i_rd_req_ready) r_cnt <= '0;
        RF_DATA: begin
          if (i_rd_data_valid) begin
            r_refill[w_slotBase +: DATA_WIDTH] <= i_rd_data;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_stall      = (r_state != IDLE) | w_miss;
  assign o_wr_addr    = r_wbAddr;
  assign o_rd_addr    = r_rfAddr;
  assign o_wr_data    = r_victim[w_slotBase +: DATA_WIDTH];
  assign o_data_block = r_refill;

`ifdef DCACHE_MISS_CNT_EN
  logic [31:0] r_missCount;
  logic [31:0] r_wbCount;

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      r_missCount <= '0;
      r_wbCount   <= '0;
    end else if ((r_state == IDLE) && w_miss) begin
      if (r_missCount != '1) r_missCount <= r_missCount + 1'b1;
      if (i_dcache_dirty && (r_wbCount != '1)) r_wbCount <= r_wbCount + 1'b1;
    end
  end

  assign o_miss_count = r_missCount;
  assign o_wb_count   = r_wbCount;
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Randomized bench for dcache_miss_ctrl: the bench plays the memory bus and
// predicts every bus cycle from the handshakes it has itself granted.
module tb_dcache_miss_ctrl;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = 512;
  localparam int NB = BW / DW;

  logic          i_clk = 1'b0;
  logic          i_arst;
  logic          i_mem_access, i_dcache_hit, i_dcache_dirty;
  logic [AW-1:0] i_addr, i_addr_wb;
  logic [BW-1:0] i_victim_block;
  logic          o_stall, o_block_we;
  logic [BW-1:0] o_data_block;
  logic          o_wr_req_valid, i_wr_req_ready;
  logic [AW-1:0] o_wr_addr;
  logic          o_wr_data_valid, i_wr_data_ready;
  logic [DW-1:0] o_wr_data;
  logic          o_wr_last, i_wr_resp_valid;
  logic          o_rd_req_valid, i_rd_req_ready;
  logic [AW-1:0] o_rd_addr;
  logic          i_rd_data_valid;
  logic [DW-1:0] i_rd_data;
`ifdef DCACHE_MISS_CNT_EN
  logic [31:0]   o_miss_count, o_wb_count;
`endif

  int nChecks = 0;
  int nBad    = 0;
  int expMiss = 0;
  int expWb   = 0;

  dcache_miss_ctrl dut (
    .i_clk(i_clk), .i_arst(i_arst),
    .i_mem_access(i_mem_access), .i_dcache_hit(i_dcache_hit), .i_dcache_dirty(i_dcache_dirty),
    .i_addr(i_addr), .i_addr_wb(i_addr_wb), .i_victim_block(i_victim_block),
    .o_stall(o_stall), .o_block_we(o_block_we), .o_data_block(o_data_block),
    .o_wr_req_valid(o_wr_req_valid), .i_wr_req_ready(i_wr_req_ready), .o_wr_addr(o_wr_addr),
    .o_wr_data_valid(o_wr_data_valid), .i_wr_data_ready(i_wr_data_ready), .o_wr_data(o_wr_data),
    .o_wr_last(o_wr_last), .i_wr_resp_valid(i_wr_resp_valid),
    .o_rd_req_valid(o_rd_req_valid), .i_rd_req_ready(i_rd_req_ready), .o_rd_addr(o_rd_addr),
    .i_rd_data_valid(i_rd_data_valid), .i_rd_data(i_rd_data)
`ifdef DCACHE_MISS_CNT_EN
    , .o_miss_count(o_miss_count), .o_wb_count(o_wb_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [BW-1:0] actual, input logic [BW-1:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nBad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [BW-1:0] randLine();
    logic [BW-1:0] v;
    for (int k = 0; k < BW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] randAddr();
    return {$urandom, $urandom};
  endfunction

  function automatic bit pickReady(input int mode, input int waited);
    if (mode == 1) return bit'($urandom_range(0, 1));
    if (mode == 2) return waited >= 3;
    return 1'b1;
  endfunction

  task automatic applyStimulus(input bit access, input bit hit, input bit dirty,
                               input logic [AW-1:0] addr, input logic [AW-1:0] addrWb,
                               input logic [BW-1:0] victim);
    i_mem_access   = access;
    i_dcache_hit   = hit;
    i_dcache_dirty = dirty;
    i_addr         = addr;
    i_addr_wb      = addrWb;
    i_victim_block = victim;
  endtask

  task automatic quietBus();
    i_wr_req_ready  = 1'b0;
    i_wr_data_ready = 1'b0;
    i_wr_resp_valid = 1'b0;
    i_rd_req_ready  = 1'b0;
    i_rd_data_valid = 1'b0;
    i_rd_data       = '0;
  endtask

  task automatic idleCheck(input string tag);
    #1;
    checkOutput({tag, "_stall"}, o_stall, 0);
    checkOutput({tag, "_wrreq"}, o_wr_req_valid, 0);
    checkOutput({tag, "_wrdata"}, o_wr_data_valid, 0);
    checkOutput({tag, "_wrlast"}, o_wr_last, 0);
    checkOutput({tag, "_rdreq"}, o_rd_req_valid, 0);
    checkOutput({tag, "_we"}, o_block_we, 0);
  endtask

  // Hits and non-accesses must never disturb the controller
  task automatic noMissCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      applyStimulus(1'b1, 1'b1, bit'($urandom_range(0, 1)), randAddr(), randAddr(), randLine());
      idleCheck("hit");
      @(negedge i_clk);
      applyStimulus(1'b0, 1'b0, bit'($urandom_range(0, 1)), randAddr(), randAddr(), randLine());
      idleCheck("noacc");
    end
  endtask

  // One miss from acceptance to commit (or to a mid-refill reset when abortAt > 0)
  task automatic runMiss(input bit dirty, input logic [AW-1:0] addr, input logic [AW-1:0] addrWb,
                         input logic [BW-1:0] victim, input logic [BW-1:0] line,
                         input int mode, input int abortAt);
    logic [AW-1:0] expWbAddr;
    logic [AW-1:0] expRfAddr;
    bit wrReqDone, respDone, rdReqDone, finished, expWrReq, expWrData, expRdReq, expWe, respPulse, realBeat;
    int beatsSent, rdBeats, respDelay, waitReq, waitData, waitRd;
    expWbAddr = addrWb & ~64'h3F;
    expRfAddr = addr & ~64'h3F;
    wrReqDone = 0; respDone = 0; rdReqDone = 0; finished = 0;
    beatsSent = 0; rdBeats = 0; waitReq = 0; waitData = 0; waitRd = 0;
    respDelay = $urandom_range(0, 3);

    @(negedge i_clk);
    quietBus();
    applyStimulus(1'b1, 1'b0, dirty, addr, addrWb, victim);
    #1;
    checkOutput("stall_in_miss_cycle", o_stall, 1);
    checkOutput("we_in_miss_cycle", o_block_we, 0);
    expMiss++;
    if (dirty) expWb++;

    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge i_clk);
      applyStimulus(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    randAddr(), randAddr(), randLine());
      if (abortAt > 0 && rdBeats == abortAt) begin
        quietBus();
        i_mem_access = 1'b0;
        i_arst = 1'b1;
        @(negedge i_clk);
        i_arst = 1'b0;
        expMiss = 0;
        expWb   = 0;
        idleCheck("after_reset");
        return;
      end
      expWrReq  = dirty && !wrReqDone;
      expWrData = dirty && wrReqDone && beatsSent < NB;
      expRdReq  = (!dirty || respDone) && !rdReqDone;
      expWe     = (rdBeats == NB);
      i_wr_req_ready  = pickReady(mode, waitReq);
      i_wr_data_ready = pickReady(mode, waitData);
      i_rd_req_ready  = pickReady(mode, waitRd);
      respPulse = dirty && beatsSent == NB && !respDone && respDelay == 0;
      if (dirty && beatsSent == NB && !respDone && respDelay > 0) respDelay--;
      i_wr_resp_valid = respPulse;
      if (rdReqDone && rdBeats < NB) begin
        realBeat = (mode == 1) ? bit'($urandom_range(0, 1)) : 1'b1;
        i_rd_data_valid = realBeat;
        i_rd_data = line[rdBeats*DW +: DW];
      end else begin
        realBeat = 1'b0;
        i_rd_data_valid = ($urandom_range(0, 3) == 0);
        i_rd_data = {$urandom, $urandom};
      end
      #1;
      checkOutput("stall_busy", o_stall, 1);
      checkOutput("wr_req_valid", o_wr_req_valid, expWrReq);
      checkOutput("wr_data_valid", o_wr_data_valid, expWrData);
      checkOutput("rd_req_valid", o_rd_req_valid, expRdReq);
      checkOutput("block_we", o_block_we, expWe);
      checkOutput("wr_last", o_wr_last, expWrData && beatsSent == NB - 1);
      if (expWrReq) checkOutput("wr_addr", o_wr_addr, expWbAddr);
      if (expWrData) checkOutput("wr_data", o_wr_data, victim[beatsSent*DW +: DW]);
      if (expRdReq) checkOutput("rd_addr", o_rd_addr, expRfAddr);
      if (expWe) checkOutput("data_block", o_data_block, line);

      if (expWrReq && i_wr_req_ready) wrReqDone = 1;
      else if (expWrReq) waitReq++;
      if (expWrData && i_wr_data_ready) begin
        beatsSent++;
        waitData = 0;
      end else if (expWrData) waitData++;
      if (respPulse) respDone = 1;
      if (expRdReq && i_rd_req_ready) rdReqDone = 1;
      else if (expRdReq) waitRd++;
      if (realBeat) rdBeats++;
      if (expWe) finished = 1;
    end
    if (!finished) checkOutput("timeout", 0, 1);

    @(negedge i_clk);
    quietBus();
    applyStimulus(1'b0, 1'b0, 1'b0, randAddr(), randAddr(), randLine());
    idleCheck("after_commit");
  endtask

  initial begin
    logic [BW-1:0] line;
    logic [BW-1:0] victim;
    quietBus();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    i_arst = 1'b1;
    repeat (2) @(negedge i_clk);
    idleCheck("reset");
    checkOutput("reset_data_block", o_data_block, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, randAddr(), randAddr(), randLine());
    #1 checkOutput("reset_stall_miss_term", o_stall, 1);
    @(negedge i_clk);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    idleCheck("reset_held_miss");
    i_arst = 1'b0;
    $display("[TB] reset released");

    noMissCycles(3);

    for (int k = 0; k < NB; k++) line[k*DW +: DW] = 64'h11 * (k + 1);
    runMiss(1'b0, 64'h1000_0048, randAddr(), randLine(), line, 0, 0);

    for (int k = 0; k < NB; k++) victim[k*DW +: DW] = 64'hA0 + k;
    runMiss(1'b1, randAddr(), 64'h2000_0000, victim, randLine(), 0, 0);

    $display("[TB] backpressure");
    runMiss(1'b1, randAddr(), randAddr(), randLine(), randLine(), 2, 0);
    runMiss(1'b0, randAddr(), randAddr(), randLine(), randLine(), 2, 0);

    $display("[TB] reset during refill");
    runMiss(1'b0, randAddr(), randAddr(), randLine(), randLine(), 0, 3);
    runMiss(1'b0, randAddr(), randAddr(), randLine(), randLine(), 0, 0);

    $display("[TB] random traffic");
    for (int t = 0; t < 12; t++) begin
      runMiss(bit'($urandom_range(0, 1)), randAddr(), randAddr(), randLine(), randLine(), 1, 0);
      if ($urandom_range(0, 2) == 0) noMissCycles(1);
    end

`ifdef DCACHE_MISS_CNT_EN
    #1;
    checkOutput("miss_count", o_miss_count, expMiss);
    checkOutput("wb_count", o_wb_count, expWb);
`endif

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end
endmodule
